// File: rtl/ifq_pkg.sv
// Shared constants and helpers for the instruction fetch queue.
// NOP encoding is used to pad partial fetch bundles.
package ifq_pkg;
  localparam int          IFQ_INST_W = 32;
  localparam logic [31:0] IFQ_NOP    = 32'h6000_0000;

  function automatic int ifq_clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction
endpackage

// File: rtl/ifq_ptr_ctl.sv
// Head/tail/occupancy bookkeeping for the fetch queue; emits per-slot write
// enables/indices and read indices/valids. One-cycle update, no internal backpressure.
module ifq_ptr_ctl import ifq_pkg::*; #(
  parameter int DEPTH   = 64,
  parameter int FETCH_N = 2,
  parameter int ISSUE_N = 2,
  parameter int PTR_W   = ifq_clog2(DEPTH),
  parameter int CNT_W   = ifq_clog2(DEPTH + 1),
  parameter int PC_W    = ifq_clog2(FETCH_N + 1),
  parameter int PO_W    = ifq_clog2(ISSUE_N + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_flush,
  input  logic                     i_push_valid,
  input  logic [PC_W-1:0]          i_push_cnt,
  input  logic [PO_W-1:0]          i_pop_cnt,
  output logic                     o_push_ready,
  output logic                     o_empty,
  output logic                     o_full,
  output logic                     o_err_ovf,
  output logic                     o_err_udf,
  output logic [CNT_W-1:0]         o_count,
  output logic [FETCH_N-1:0]       o_wr_en,
  output logic [FETCH_N*PTR_W-1:0] o_wr_idx,
  output logic [ISSUE_N-1:0]       o_rd_vld,
  output logic [ISSUE_N*PTR_W-1:0] o_rd_idx
);
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic             r_ovf;
  logic             r_udf;

  logic             w_push_ok;
  logic             w_push_bad;
  logic             w_pop_ok;
  logic             w_pop_bad;
  logic [CNT_W-1:0] w_pushed;
  logic [CNT_W-1:0] w_popped;

  // Readiness looks only at registered occupancy so fetch never waits on decode.
  assign o_push_ready = (CNT_W'(DEPTH) - r_count) >= CNT_W'(FETCH_N);
  assign w_push_ok    = i_push_valid && o_push_ready && !i_flush;
  assign w_push_bad   = i_push_valid && !o_push_ready && !i_flush;
  assign w_pop_bad    = !i_flush && (CNT_W'(i_pop_cnt) > r_count);
  assign w_pop_ok     = !i_flush && !w_pop_bad;
  assign w_pushed     = w_push_ok ? CNT_W'(i_push_cnt) : '0;
  assign w_popped     = w_pop_ok  ? CNT_W'(i_pop_cnt)  : '0;

  always_comb begin
    o_wr_en  = '0;
    o_wr_idx = '0;
    for (int i = 0; i < FETCH_N; i++) begin
      o_wr_en[i]                  = w_push_ok && (i < int'(i_push_cnt));
      o_wr_idx[i*PTR_W +: PTR_W]  = r_tail + PTR_W'(i);
    end
  end

  always_comb begin
    o_rd_vld = '0;
    o_rd_idx = '0;
    for (int k = 0; k < ISSUE_N; k++) begin
      o_rd_vld[k]                 = r_count > CNT_W'(k);
      o_rd_idx[k*PTR_W +: PTR_W]  = r_head + PTR_W'(k);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      if (w_push_bad) r_ovf <= 1'b1;
      if (w_pop_bad)  r_udf <= 1'b1;
      if (i_flush) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        r_head  <= r_head + PTR_W'(w_popped);
        r_tail  <= r_tail + PTR_W'(w_pushed);
        r_count <= r_count + w_pushed - w_popped;
      end
    end
  end

  assign o_count   = r_count;
  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_err_ovf = r_ovf;
  assign o_err_udf = r_udf;
endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction queue between fetch and decode: FETCH_N in, ISSUE_N out per cycle.
// Push visible one cycle later; pop is a zero-latency peek consumed on the edge.
module inst_fetch_queue import ifq_pkg::*; #(
  parameter int DEPTH   = 64,
  parameter int INST_W  = IFQ_INST_W,
  parameter int FETCH_N = 2,
  parameter int ISSUE_N = 2,
  parameter int CNT_W   = ifq_clog2(DEPTH + 1)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush,
  input  logic                            push_valid,
  input  logic [ifq_clog2(FETCH_N+1)-1:0] push_cnt,
  input  logic [FETCH_N*INST_W-1:0]       push_data,
  output logic                            push_ready,
  output logic [ISSUE_N-1:0]              pop_valid,
  output logic [ISSUE_N*INST_W-1:0]       pop_data,
  input  logic [ifq_clog2(ISSUE_N+1)-1:0] pop_cnt,
  output logic [CNT_W-1:0]                count,
  output logic                            empty,
  output logic                            full,
  output logic                            err_ovf,
  output logic                            err_udf
);
  localparam int PTR_W = ifq_clog2(DEPTH);

  logic [INST_W-1:0]        r_mem [DEPTH];
  logic [FETCH_N-1:0]       w_wr_en;
  logic [FETCH_N*PTR_W-1:0] w_wr_idx;
  logic [ISSUE_N*PTR_W-1:0] w_rd_idx;

  ifq_ptr_ctl #(
    .DEPTH   (DEPTH),
    .FETCH_N (FETCH_N),
    .ISSUE_N (ISSUE_N)
  ) u_ptr_ctl (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_flush      (flush),
    .i_push_valid (push_valid),
    .i_push_cnt   (push_cnt),
    .i_pop_cnt    (pop_cnt),
    .o_push_ready (push_ready),
    .o_empty      (empty),
    .o_full       (full),
    .o_err_ovf    (err_ovf),
    .o_err_udf    (err_udf),
    .o_count      (count),
    .o_wr_en      (w_wr_en),
    .o_wr_idx     (w_wr_idx),
    .o_rd_vld     (pop_valid),
    .o_rd_idx     (w_rd_idx)
  );

  // Slot 0 is the oldest and lives in the most-significant lane of the bundle.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_N; i++) begin
      if (w_wr_en[i])
        r_mem[w_wr_idx[i*PTR_W +: PTR_W]] <= push_data[(FETCH_N-1-i)*INST_W +: INST_W];
    end
  end

  always_comb begin
    pop_data = '0;
    for (int k = 0; k < ISSUE_N; k++) begin
      if (pop_valid[k])
        pop_data[(ISSUE_N-1-k)*INST_W +: INST_W] = r_mem[w_rd_idx[k*PTR_W +: PTR_W]];
    end
  end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomised scoreboard bench for inst_fetch_queue against a word-list reference model.
module tb_inst_fetch_queue;
  import ifq_pkg::*;

  localparam int DEPTH   = 64;
  localparam int FETCH_N = 2;
  localparam int ISSUE_N = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        push_valid = 1'b0;
  logic [1:0]  push_cnt = '0;
  logic [63:0] push_data = '0;
  logic        push_ready;
  logic [1:0]  pop_valid;
  logic [63:0] pop_data;
  logic [1:0]  pop_cnt = '0;
  logic [6:0]  count;
  logic        empty, full, err_ovf, err_udf;

  always #5 clk = ~clk;

  inst_fetch_queue #(.DEPTH(DEPTH), .INST_W(32), .FETCH_N(FETCH_N), .ISSUE_N(ISSUE_N)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .push_valid(push_valid), .push_cnt(push_cnt),
    .push_data(push_data), .push_ready(push_ready), .pop_valid(pop_valid), .pop_data(pop_data),
    .pop_cnt(pop_cnt), .count(count), .empty(empty), .full(full), .err_ovf(err_ovf),
    .err_udf(err_udf)
  );

  typedef struct {
    int          cnt;
    logic [1:0]  pv;
    logic [63:0] pd;
    logic        rdy, emp, ful, ovf, udf;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mq[$];
  logic        m_ovf = 1'b0;
  logic        m_udf = 1'b0;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t snapshot();
    exp_t e;
    e.cnt = mq.size();
    e.pv  = '0;
    e.pd  = '0;
    for (int k = 0; k < ISSUE_N; k++) begin
      if (k < mq.size()) begin
        e.pv[k] = 1'b1;
        e.pd[(ISSUE_N-1-k)*32 +: 32] = mq[k];
      end
    end
    e.rdy = (DEPTH - mq.size()) >= FETCH_N;
    e.emp = (mq.size() == 0);
    e.ful = (mq.size() == DEPTH);
    e.ovf = m_ovf;
    e.udf = m_udf;
    return e;
  endfunction

  // Reference: the queue is just an ordered list of words.
  function automatic void model_step(input logic fl, input logic pv, input int pc,
                                     input logic [31:0] d0, input logic [31:0] d1, input int popc);
    logic ready;
    ready = (DEPTH - mq.size()) >= FETCH_N;
    if (fl) begin
      mq.delete();
    end else begin
      if (popc > mq.size()) m_udf = 1'b1;
      else for (int i = 0; i < popc; i++) void'(mq.pop_front());
      if (pv) begin
        if (!ready) m_ovf = 1'b1;
        else begin
          if (pc >= 1) mq.push_back(d0);
          if (pc >= 2) mq.push_back(d1);
        end
      end
    end
  endfunction

  task automatic cyc(input logic fl, input logic pv, input int pc,
                     input logic [31:0] d0, input logic [31:0] d1, input int popc);
    @(posedge clk);
    #1;
    exp_q.push_back(snapshot());
    rst_n      = 1'b1;
    flush      = fl;
    push_valid = pv;
    push_cnt   = 2'(pc);
    push_data  = {d0, d1};
    pop_cnt    = 2'(popc);
    model_step(fl, pv, pc, d0, d1, popc);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 0, IFQ_NOP, IFQ_NOP, 0);
  endtask

  task automatic async_reset();
    @(posedge clk);
    #7;
    rst_n = 1'b0;
    #1;
    chk("async_rst_count", 64'(count), 64'd0);
    chk("async_rst_udf", 64'(err_udf), 64'd0);
    chk("async_rst_ovf", 64'(err_ovf), 64'd0);
    chk("async_rst_empty", 64'(empty), 64'd1);
    chk("async_rst_ready", 64'(push_ready), 64'd1);
    mq.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    flush = 1'b0; push_valid = 1'b0; push_cnt = '0; pop_cnt = '0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("count", 64'(count), 64'(e.cnt));
        chk("pop_valid", 64'(pop_valid), 64'(e.pv));
        chk("pop_data", pop_data, e.pd);
        chk("push_ready", 64'(push_ready), 64'(e.rdy));
        chk("empty", 64'(empty), 64'(e.emp));
        chk("full", 64'(full), 64'(e.ful));
        chk("err_ovf", 64'(err_ovf), 64'(e.ovf));
        chk("err_udf", 64'(err_udf), 64'(e.udf));
      end
    end
  end

  initial begin : driver
    int popc, pc, waited;
    // reset defaults, then a single two-word bundle
    idle(); idle();
    cyc(1'b0, 1'b1, 2, 32'h3860_0001, 32'h3880_0002, 0);
    idle();
    // fill to full, overflow attempt, then drain two
    cyc(1'b1, 1'b0, 0, IFQ_NOP, IFQ_NOP, 0);
    for (int i = 0; i < 32; i++) cyc(1'b0, 1'b1, 2, 32'h1000_0000 + 32'(2*i), 32'h1000_0001 + 32'(2*i), 0);
    cyc(1'b0, 1'b1, 2, 32'hDEAD_0001, 32'hDEAD_0002, 0);
    cyc(1'b0, 1'b0, 0, IFQ_NOP, IFQ_NOP, 2);
    idle();
    // walk pointers to 63 with an empty queue, then a bundle across the wrap point
    async_reset();
    for (int i = 0; i < 63; i++) cyc(1'b0, 1'b1, 1, 32'h2000_0000 + 32'(i), IFQ_NOP, mq.size());
    cyc(1'b0, 1'b0, 0, IFQ_NOP, IFQ_NOP, mq.size());
    cyc(1'b0, 1'b1, 2, 32'hAAAA_AAAA, 32'hBBBB_BBBB, 0);
    cyc(1'b0, 1'b0, 0, IFQ_NOP, IFQ_NOP, 2);
    idle();
    // simultaneous push/pop from five entries, then flush racing a push
    cyc(1'b0, 1'b1, 2, 32'h3000_0001, 32'h3000_0002, 0);
    cyc(1'b0, 1'b1, 2, 32'h3000_0003, 32'h3000_0004, 0);
    cyc(1'b0, 1'b1, 1, 32'h3000_0005, IFQ_NOP, 0);
    cyc(1'b0, 1'b1, 2, 32'h3000_0006, 32'h3000_0007, 1);
    cyc(1'b1, 1'b1, 2, 32'h3000_0008, 32'h3000_0009, 1);
    idle();
    // push_cnt=0 no-op, underflow with one entry, then async reset mid-cycle
    cyc(1'b0, 1'b1, 0, 32'h4000_0000, IFQ_NOP, 0);
    cyc(1'b0, 1'b1, 1, 32'h4000_0001, IFQ_NOP, 0);
    cyc(1'b0, 1'b0, 0, IFQ_NOP, IFQ_NOP, 2);
    idle();
    async_reset();
    // random traffic across many wraps
    for (int n = 0; n < 3000; n++) begin
      logic pv, fl;
      fl    = ($urandom_range(0, 49) == 0);
      pv    = ($urandom_range(0, 99) < 55) && ((DEPTH - mq.size()) >= FETCH_N);
      pc    = $urandom_range(0, FETCH_N);
      popc  = $urandom_range(0, ISSUE_N);
      if (popc > mq.size()) popc = mq.size();
      cyc(fl, pv, pc, $urandom, $urandom, popc);
    end
    idle(); idle();
    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    if (exp_q.size() > 0) chk("scoreboard_drain", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
Parametrised instruction queue between fetch and decode. Accepts up to FETCH_N instructions per cycle from the fetch path and presents up to ISSUE_N oldest instructions per cycle to decode. Provides real full/empty tracking, fetch backpressure, pipeline flush, and sticky overflow/underflow error flags. It supersedes the fixed 64-entry, 2-in/2-out queue built into the core top level.

Parameters:
DEPTH, 64, entry count; power of two, at least 2*FETCH_N.
INST_W, 32, instruction width in bits.
FETCH_N, 2, maximum instructions pushed per cycle; 1..4.
ISSUE_N, 2, maximum instructions popped per cycle; 1..4.
CNT_W, clog2(DEPTH+1), width of occupancy count (derived).

Ports:
clk  in  1  rising-edge clock.
rst_n  in  1  asynchronous active-low reset.
flush  in  1  discard all entries (branch redirect).
push_valid  in  1  fetch presents a bundle this cycle.
push_cnt  in  clog2(FETCH_N+1)  number of valid slots in the bundle, 1..FETCH_N; slots 0..push_cnt-1 are valid.
push_data  in  FETCH_N*INST_W  bundle; slot 0 (oldest) in the most-significant INST_W bits.
push_ready  out  1  queue can accept a full FETCH_N bundle.
pop_valid  out  ISSUE_N  bit k=1 when entry head+k exists.
pop_data  out  ISSUE_N*INST_W  entries head..head+ISSUE_N-1; slot 0 in the most-significant bits.
pop_cnt  in  clog2(ISSUE_N+1)  number of entries decode consumes this cycle.
count  out  CNT_W  current occupancy.
empty  out  1  count==0.
full  out  1  count==DEPTH.
err_ovf  out  1  sticky: push attempted while push_ready=0.
err_udf  out  1  sticky: pop_cnt exceeded count.

Behaviour:
- Reset (async assert, sync release): head=tail=0, count=0, empty=1, full=0, push_ready=1, pop_valid=0, err_ovf=err_udf=0. Storage contents are don't-care; pop_data is masked to 0 when pop_valid bit is 0.
- push_ready = (DEPTH - count) >= FETCH_N. It depends on registered count only and not on the same-cycle pop_cnt.
- Push takes effect when push_valid && push_ready && !flush. Slot i is written at (tail+i) mod DEPTH for i < push_cnt. tail advances by push_cnt.
- Pop: pop_data and pop_valid are combinational from the registered head and count, so there is zero-latency peek. Decode consumes on the clock edge: head advances by pop_cnt, taking effect only if !flush and pop_cnt <= count.
- Simultaneous push and pop are legal in the same cycle: count_next = count + pushed - popped. A word pushed in cycle N is visible on pop_data in cycle N+1 (1-cycle latency through an empty queue; no bypass).
- Wrap-around: pointers are log2(DEPTH) bits and wrap modulo DEPTH. Multi-slot pushes and pops spanning the wrap point are handled per slot.
- Full/empty are derived from count, never from pointer equality.
- flush: on the next edge head=tail=count=0. Same-cycle push and pop are ignored. Error flags are not cleared.
- Illegal push (push_valid && !push_ready && !flush): no state change; err_ovf is set.
- Illegal pop (pop_cnt > count && !flush): no head movement; err_udf is set.
- push_cnt=0 with push_valid=1 is a no-op and not an error.
- Reset asserted mid-operation: all state returns to reset values immediately (async). Errors are cleared only by reset.

Decomposition:
- Shared package ifq_pkg: INST_W default, a NOP encoding constant (32'h60000000, ori 0,0,0) for bench padding, and a clog2 function.
- One natural sub-module: ifq_ptr_ctl. It holds head/tail/count arithmetic and flags and emits write enables and read indices. Storage and output muxing stay in inst_fetch_queue.

Test Plan:
- Reset then idle (defaults) -> count=0, empty=1, push_ready=1, pop_valid=2'b00, err flags 0.
- Push bundle {0x38600001,0x38800002} with push_cnt=2, no pop -> next cycle count=2, pop_valid=2'b11, pop_data slot0=0x38600001, slot1=0x38800002.
- Fill with 32 pushes of 2 and no pops -> count=64, full=1, push_ready=0. A 33rd push sets err_ovf=1 with count still 64. Then pop_cnt=2 -> count=62, push_ready=1.
- Wrap: preload so head=tail=63 with count=0. Push {A,B} -> A at index 63, B at index 0. Pop_cnt=2 next cycle -> returns A then B in slot order, head=1, empty=1.
- Simultaneous push 2 / pop 1 from count=5 -> count=6. Flush with a concurrent push -> count=0, pushed data discarded, empty=1.
- count=1 with pop_cnt=2 -> err_udf=1, head unchanged, count=1. Assert rst_n=0 mid-cycle -> count=0 and err_udf=0 without waiting for a clock edge.
